// File: rtl/systolic_array_if.sv
// Operand/result bundle of the systolic MAC core: mode select, two input
// planes, three weight channels and the three partial-sum outputs.
interface systolic_array_if #(
  parameter int N    = 8,
  parameter int ROWS = 4,
  parameter int COLS = 8
);
  localparam int L = ROWS * COLS;

  logic             select0;
  logic             select1;
  logic [L*N-1:0]   in0;
  logic [L*N-1:0]   in1;
  logic [L*N-1:0]   w0;
  logic [L*N-1:0]   w1;
  logic [L*N-1:0]   w2;
  logic [L*2*N-1:0] out0;
  logic [L*2*N-1:0] out1;
  logic [L*2*N-1:0] out2;

  modport master (
    output select0, select1, in0, in1, w0, w1, w2,
    input  out0, out1, out2
  );

  modport slave (
    input  select0, select1, in0, in1, w0, w1, w2,
    output out0, out1, out2
  );
endinterface

// File: rtl/systolic_array.sv
// ROWS x COLS grid of independent MAC processing elements. Each PE owns one
// lane, multiplies the selected input plane(s) by its three lane weights and
// accumulates into three wrapping 2N-bit partial sums that drive the outputs.
module systolic_array #(
  parameter int N    = 8,
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            reset,
  systolic_array_if.slave bus
);
  localparam int W = 2 * N;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_P0   = 2'b01,
    MODE_P1   = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'({bus.select1, bus.select0});

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int LANE = r * COLS + c;

      // Operands zero-extended to 2N bits so products and sums wrap mod 2^(2N).
      logic [W-1:0] x0;
      logic [W-1:0] x1;
      logic [W-1:0] wt    [3];
      logic [W-1:0] acc_q [3];
      logic [W-1:0] acc_d [3];

      assign x0    = W'(bus.in0[N*LANE +: N]);
      assign x1    = W'(bus.in1[N*LANE +: N]);
      assign wt[0] = W'(bus.w0[N*LANE +: N]);
      assign wt[1] = W'(bus.w1[N*LANE +: N]);
      assign wt[2] = W'(bus.w2[N*LANE +: N]);

      // Single-cycle multiply-add of the selected plane(s) into each channel.
      always_comb begin
        for (int k = 0; k < 3; k++) begin
          // NOTE: default to the held value first so no path leaves acc_d unassigned (no latch).
          acc_d[k] = acc_q[k];
          unique case (mode)
            MODE_HOLD: acc_d[k] = acc_q[k];
            MODE_P0:   acc_d[k] = acc_q[k] + x0 * wt[k];
            MODE_P1:   acc_d[k] = acc_q[k] + x1 * wt[k];
            MODE_BOTH: acc_d[k] = acc_q[k] + x0 * wt[k] + x1 * wt[k];
          endcase
        end
      end

      // Partial-sum registers; reset has priority over any mode.
      always_ff @(posedge clk) begin
        // NOTE: the PSUM array is architecturally visible state, so it is cleared on reset, not left as uninitialised storage.
        if (reset) begin
          for (int k = 0; k < 3; k++) acc_q[k] <= '0;
        end else begin
          // NOTE: non-blocking assignments keep every PE's register update order-independent.
          for (int k = 0; k < 3; k++) acc_q[k] <= acc_d[k];
        end
      end

      assign bus.out0[W*LANE +: W] = acc_q[0];
      assign bus.out1[W*LANE +: W] = acc_q[1];
      assign bus.out2[W*LANE +: W] = acc_q[2];
    end
  end
endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: expectations are queued when
// stimulus is driven and compared against the outputs after the clock edge.
module tb_systolic_array;
  localparam int N    = 8;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int L    = ROWS * COLS;

  typedef struct {
    string       name;
    int          lane;
    int          ch;
    logic [15:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  int   n_checks;
  int   n_pass;
  logic [15:0] model [L][3];

  systolic_array_if #(.N(N), .ROWS(ROWS), .COLS(COLS)) bus ();

  systolic_array #(.N(N), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] get_out(int ch, int lane);
    case (ch)
      0:       return bus.out0[16*lane +: 16];
      1:       return bus.out1[16*lane +: 16];
      default: return bus.out2[16*lane +: 16];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(logic [1:0] m);
    bus.select1 = m[1];
    bus.select0 = m[0];
  endtask

  task automatic clear_data();
    bus.in0 = '0; bus.in1 = '0;
    bus.w0  = '0; bus.w1  = '0; bus.w2 = '0;
  endtask

  task automatic set_lane(int l, logic [7:0] a0, logic [7:0] a1,
                          logic [7:0] k0, logic [7:0] k1, logic [7:0] k2);
    bus.in0[8*l +: 8] = a0;
    bus.in1[8*l +: 8] = a1;
    bus.w0[8*l +: 8]  = k0;
    bus.w1[8*l +: 8]  = k1;
    bus.w2[8*l +: 8]  = k2;
  endtask

  task automatic push(string name, int lane, int ch, logic [15:0] exp);
    exp_t e;
    e.name = name; e.lane = lane; e.ch = ch; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic push_all_zero(string name);
    for (int l = 0; l < L; l++)
      for (int k = 0; k < 3; k++) push(name, l, k, 16'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] m;
    reset = 1'b1;
    m = 2'($urandom_range(3));
    set_mode(m);
    for (int i = 0; i < L * N / 32; i++) begin
      bus.in0[32*i +: 32] = $urandom; bus.in1[32*i +: 32] = $urandom;
      bus.w0[32*i +: 32]  = $urandom; bus.w1[32*i +: 32]  = $urandom;
      bus.w2[32*i +: 32]  = $urandom;
    end
    push_all_zero("reset_clear");
    tick();
    reset = 1'b0;
    set_mode(2'b00);
    while (sb_q.size() > 0) begin
      exp_t e; logic [15:0] got;
      e = sb_q.pop_front(); got = get_out(e.ch, e.lane); n_checks++;
      if (got !== e.exp) $display("FAIL %s lane=%0d ch=%0d got=%0d exp=%0d", e.name, e.lane, e.ch, got, e.exp);
      else n_pass++;
    end
    for (int c = 0; c < 3; c++) begin
      push_all_zero("reset_hold");
      tick();
      while (sb_q.size() > 0) begin
        exp_t e; logic [15:0] got;
        e = sb_q.pop_front(); got = get_out(e.ch, e.lane); n_checks++;
        if (got !== e.exp) $display("FAIL %s lane=%0d ch=%0d got=%0d exp=%0d", e.name, e.lane, e.ch, got, e.exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mode01();
    logic [7:0]  a  [4] = '{8'd1, 8'd2, 8'd1, 8'd2};
    logic [7:0]  k0 [4] = '{8'd4, 8'd5, 8'd5, 8'd3};
    logic [7:0]  k1 [4] = '{8'd3, 8'd1, 8'd2, 8'd5};
    logic [7:0]  k2 [4] = '{8'd5, 8'd4, 8'd4, 8'd4};
    logic [15:0] e0 [4] = '{16'd4, 16'd14, 16'd19, 16'd25};
    logic [15:0] e1 [4] = '{16'd3, 16'd5,  16'd7,  16'd17};
    logic [15:0] e2 [4] = '{16'd5, 16'd13, 16'd17, 16'd25};
    clear_data();
    apply_reset();
    set_mode(2'b01);
    for (int i = 0; i < 4; i++) begin
      set_lane(0, a[i], 8'($urandom), k0[i], k1[i], k2[i]);
      push("mode01", 0, 0, e0[i]);
      push("mode01", 0, 1, e1[i]);
      push("mode01", 0, 2, e2[i]);
      tick();
      while (sb_q.size() > 0) begin
        exp_t e; logic [15:0] got;
        e = sb_q.pop_front(); got = get_out(e.ch, e.lane); n_checks++;
        if (got !== e.exp) $display("FAIL %s lane=%0d ch=%0d got=%0d exp=%0d", e.name, e.lane, e.ch, got, e.exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_modes_10_11();
    logic [1:0]  m  [4] = '{2'b10, 2'b11, 2'b00, 2'b00};
    logic [15:0] ex [4] = '{16'd8, 16'd28, 16'd28, 16'd28};
    clear_data();
    apply_reset();
    set_lane(0, 8'd3, 8'd2, 8'd4, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      set_mode(m[i]);
      push("modes_10_11", 0, 0, ex[i]);
      tick();
      while (sb_q.size() > 0) begin
        exp_t e; logic [15:0] got;
        e = sb_q.pop_front(); got = get_out(e.ch, e.lane); n_checks++;
        if (got !== e.exp) $display("FAIL %s lane=%0d ch=%0d got=%0d exp=%0d", e.name, e.lane, e.ch, got, e.exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ex [2] = '{16'd65025, 16'd64514};
    clear_data();
    apply_reset();
    set_mode(2'b01);
    set_lane(31, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255);
    for (int i = 0; i < 2; i++) begin
      push("wrap", 31, 2, ex[i]);
      push("wrap_ch0", 31, 0, 16'd0);
      tick();
      while (sb_q.size() > 0) begin
        exp_t e; logic [15:0] got;
        e = sb_q.pop_front(); got = get_out(e.ch, e.lane); n_checks++;
        if (got !== e.exp) $display("FAIL %s lane=%0d ch=%0d got=%0d exp=%0d", e.name, e.lane, e.ch, got, e.exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_data();
    apply_reset();
    set_mode(2'b01);
    set_lane(0, 8'd2, 8'd0, 8'd3, 8'd0, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin
        reset = 1'b1;
        push_all_zero("reset_mid_clear");
      end else begin
        push("reset_mid_accum", 0, 0, 16'(6 * i));
      end
      tick();
      while (sb_q.size() > 0) begin
        exp_t e; logic [15:0] got;
        e = sb_q.pop_front(); got = get_out(e.ch, e.lane); n_checks++;
        if (got !== e.exp) $display("FAIL %s lane=%0d ch=%0d got=%0d exp=%0d", e.name, e.lane, e.ch, got, e.exp);
        else n_pass++;
      end
    end
    reset = 1'b0;
    set_lane(0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0);
    push("reset_mid_resume", 0, 0, 16'd1);
    push("reset_mid_resume", 0, 1, 16'd0);
    push("reset_mid_resume", 0, 2, 16'd0);
    tick();
    while (sb_q.size() > 0) begin
      exp_t e; logic [15:0] got;
      e = sb_q.pop_front(); got = get_out(e.ch, e.lane); n_checks++;
      if (got !== e.exp) $display("FAIL %s lane=%0d ch=%0d got=%0d exp=%0d", e.name, e.lane, e.ch, got, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_lanes();
    clear_data();
    apply_reset();
    for (int l = 0; l < L; l++)
      for (int k = 0; k < 3; k++) model[l][k] = 16'd0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      logic [1:0] m;
      m = 2'($urandom_range(3));
      set_mode(m);
      for (int l = 0; l < L; l++) begin
        logic [7:0] a0, a1;
        logic [7:0] wk [3];
        a0 = 8'($urandom); a1 = 8'($urandom);
        for (int k = 0; k < 3; k++) wk[k] = 8'($urandom);
        set_lane(l, a0, a1, wk[0], wk[1], wk[2]);
        for (int k = 0; k < 3; k++) begin
          int unsigned sum;
          sum = model[l][k];
          if (m[0]) sum += a0 * wk[k];
          if (m[1]) sum += a1 * wk[k];
          model[l][k] = 16'(sum);
          push("lanes", l, k, model[l][k]);
        end
      end
      tick();
      while (sb_q.size() > 0) begin
        exp_t e; logic [15:0] got;
        e = sb_q.pop_front(); got = get_out(e.ch, e.lane); n_checks++;
        if (got !== e.exp) $display("FAIL %s lane=%0d ch=%0d got=%0d exp=%0d", e.name, e.lane, e.ch, got, e.exp);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    set_mode(2'b00);
    clear_data();
    #1;
    test_reset();
    test_mode01();
    test_modes_10_11();
    test_wrap();
    test_reset_mid();
    test_lanes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
